// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one ALU between two requesters, with a
//            one-entry response register and the architectural {Z,C,N,V} SR.
//            Optional requester locking when ALU_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int DW  = 32,
   parameter int SRW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0,
   input  logic           req1,
   input  logic [3:0]     cmd0,
   input  logic [3:0]     cmd1,
   input  logic [DW-1:0]  a0,
   input  logic [DW-1:0]  a1,
   input  logic [DW-1:0]  b0,
   input  logic [DW-1:0]  b1,
   input  logic           s0,
   input  logic           s1,
`ifdef ALU_ARB_LOCK_EN
   input  logic           lock0,
   input  logic           lock1,
`endif
   output logic           gnt0,
   output logic           gnt1,
   output logic [DW-1:0]  alu_first,
   output logic [DW-1:0]  alu_second,
   output logic [3:0]     alu_exe_cmd,
   output logic [SRW-1:0] alu_sr,
   input  logic [DW-1:0]  alu_result,
   input  logic [SRW-1:0] alu_status,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [DW-1:0]  rsp_result,
   output logic [SRW-1:0] rsp_status,
   output logic           rsp_err,
   output logic [SRW-1:0] sr
);

   localparam logic [3:0] c_cmd_idle      = 4'b0000;
   localparam logic [3:0] c_cmd_legal_max = 4'b1001;

   logic           r_rsp_valid;
   logic           r_rsp_id;
   logic [DW-1:0]  r_rsp_result;
   logic [SRW-1:0] r_rsp_status;
   logic           r_rsp_err;
   logic [SRW-1:0] r_sr;
   logic           r_prio;

   logic           w_can_issue;
   logic           w_req0_eff;
   logic           w_req1_eff;
   logic           w_lock_active;
   logic           w_gnt0;
   logic           w_gnt1;
   logic           w_any_gnt;
   logic           w_sel_s;
   logic           w_legal;

`ifdef ALU_ARB_LOCK_EN
   logic           r_locked;
   logic           r_owner;
   logic           w_sel_lock;

   // Ownership lapses as soon as the owner stops requesting.
   assign w_lock_active = r_locked & (r_owner ? req1 : req0);
   assign w_req0_eff    = req0 & ~(w_lock_active &  r_owner);
   assign w_req1_eff    = req1 & ~(w_lock_active & ~r_owner);
   assign w_sel_lock    = w_gnt1 ? lock1 : lock0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked <= 1'b0;
         r_owner  <= 1'b0;
      end else if (w_any_gnt) begin
         r_locked <= w_sel_lock;
         r_owner  <= w_gnt1;
      end else if (!w_lock_active) begin
         r_locked <= 1'b0;
      end
   end
`else
   assign w_lock_active = 1'b0;
   assign w_req0_eff    = req0;
   assign w_req1_eff    = req1;
`endif

   // Reset gates issue so grants and ALU drive drop immediately with rst_n.
   assign w_can_issue = rst_n & (~r_rsp_valid | rsp_ready);

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_can_issue) begin
         if (w_req0_eff && w_req1_eff) begin
            w_gnt0 = ~r_prio;
            w_gnt1 =  r_prio;
         end else begin
            w_gnt0 = w_req0_eff;
            w_gnt1 = w_req1_eff;
         end
      end
   end

   assign w_any_gnt = w_gnt0 | w_gnt1;
   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;

   always_comb begin
      alu_first   = '0;
      alu_second  = '0;
      alu_exe_cmd = c_cmd_idle;
      w_sel_s     = 1'b0;
      if (w_gnt1) begin
         alu_first   = a1;
         alu_second  = b1;
         alu_exe_cmd = cmd1;
         w_sel_s     = s1;
      end else if (w_gnt0) begin
         alu_first   = a0;
         alu_second  = b0;
         alu_exe_cmd = cmd0;
         w_sel_s     = s0;
      end
   end

   assign w_legal = (alu_exe_cmd != c_cmd_idle) && (alu_exe_cmd <= c_cmd_legal_max);
   assign alu_sr  = r_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_status <= '0;
         r_rsp_err    <= 1'b0;
         r_sr         <= '0;
         r_prio       <= 1'b0;
      end else begin
         if (w_any_gnt) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_gnt1;
            r_rsp_result <= w_legal ? alu_result : '0;
            r_rsp_status <= w_legal ? alu_status : '0;
            r_rsp_err    <= ~w_legal;
            if (w_sel_s && w_legal) begin
               r_sr <= alu_status;
            end
            if (!w_lock_active) begin
               r_prio <= ~w_gnt1;
            end
         end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_status = r_rsp_status;
   assign rsp_err    = r_rsp_err;
   assign sr         = r_sr;

endmodule
`default_nettype wire
